// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: default geometry, the
// fwd_sel encodings and the width helpers for the per-port select bus.
package reg_scoreboard_pkg;

    localparam int unsigned NUM_RD_DEF     = 2;
    localparam int unsigned DEPTH_DEF      = 3;
    localparam int unsigned ADDR_W_DEF     = 5;
    localparam int unsigned LOAD_STAGE_DEF = 1;

    // fwd_sel value meaning "take the operand from the register file";
    // value s+1 means "forward from tracked stage s".
    localparam int unsigned FWD_RF = 0;

    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned sel_bus_width(input int unsigned num_rd, input int unsigned depth);
        return num_rd * sel_width(depth);
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID-stage hazard query bus: operand/destination info in, forwarding selects
// and the ID stall out. The ID stage is the master, the scoreboard the slave.
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_RD = NUM_RD_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic                                    stall_in;
    logic                                    flush;
    logic                                    id_valid;
    logic [NUM_RD-1:0]                       reg_read_en;
    logic [NUM_RD*ADDR_W-1:0]                reg_read_addr;
    logic                                    reg_write_en;
    logic [ADDR_W-1:0]                       reg_write_addr;
    logic                                    is_load;
    logic                                    cp_read_en;
    logic [ADDR_W-1:0]                       cp_read_addr;
    logic                                    cp_write_en;
    logic [ADDR_W-1:0]                       cp_write_addr;
    logic [sel_bus_width(NUM_RD, DEPTH)-1:0] fwd_sel;
    logic                                    id_stall;

    modport master (
        output stall_in, flush, id_valid, reg_read_en, reg_read_addr,
               reg_write_en, reg_write_addr, is_load,
               cp_read_en, cp_read_addr, cp_write_en, cp_write_addr,
        input  fwd_sel, id_stall
    );

    modport slave (
        input  stall_in, flush, id_valid, reg_read_en, reg_read_addr,
               reg_write_en, reg_write_addr, is_load,
               cp_read_en, cp_read_addr, cp_write_en, cp_write_addr,
        output fwd_sel, id_stall
    );

endinterface

// File: rtl/reg_scoreboard_match.sv
// One read port checked against the tracked entries: the youngest matching
// producer either forwards (result ready) or forces a stall.
module reg_sb_match
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned SEL_W  = sel_width(DEPTH_DEF)
) (
    input  logic                    en,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DEPTH-1:0]        ent_valid,
    input  logic [DEPTH*ADDR_W-1:0] ent_addr,
    input  logic [DEPTH*SEL_W-1:0]  ent_rdy,
    output logic [SEL_W-1:0]        fwd_sel,
    output logic                    stall
);
    logic             hit;
    logic [SEL_W-1:0] hit_idx;
    logic [SEL_W-1:0] hit_rdy;

    // Stage 0 is the youngest, so the first match in ascending order wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_rdy = '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            if (!hit && ent_valid[s] && (ent_addr[s*ADDR_W +: ADDR_W] == addr)) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(s);
                hit_rdy = ent_rdy[s*SEL_W +: SEL_W];
            end
        end
    end

    always_comb begin
        fwd_sel = SEL_W'(FWD_RF);
        stall   = 1'b0;
        if (en && (addr != '0) && hit) begin
            if (hit_idx >= hit_rdy) begin
                fwd_sel = hit_idx + SEL_W'(1);
            end else begin
                stall = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage hazard tracker: shift pipeline of in-flight GPR writes mirroring EX..WB,
// per-port forwarding select and ID stall. Define REG_SCOREBOARD_CP0_EN for mtc0->mfc0 interlock.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_RD     = NUM_RD_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned LOAD_STAGE = LOAD_STAGE_DEF
) (
    input logic           clk,
    input logic           rst,
    reg_scoreboard_if.slave sb
);
    localparam int unsigned SEL_W = sel_width(DEPTH);

    logic [DEPTH-1:0]        gpr_valid_q;
    logic [ADDR_W-1:0]       gpr_addr_q [DEPTH];
    logic [SEL_W-1:0]        gpr_rdy_q  [DEPTH];
    logic [DEPTH*ADDR_W-1:0] gpr_addr_flat;
    logic [DEPTH*SEL_W-1:0]  gpr_rdy_flat;
    logic [NUM_RD-1:0]       port_stall;
    logic [NUM_RD*SEL_W-1:0] fwd_sel_flat;
    logic                    cp_stall;
    logic                    id_stall;
    logic                    advance;
    logic                    gpr_load;

    assign advance  = ~sb.stall_in;
    assign gpr_load = sb.id_valid & sb.reg_write_en & ~id_stall & (sb.reg_write_addr != '0);

    always_ff @(posedge clk) begin
        if (rst || sb.flush) begin
            gpr_valid_q <= '0;
        end else if (advance) begin
            gpr_valid_q[0] <= gpr_load;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                gpr_valid_q[s] <= gpr_valid_q[s-1];
            end
        end
    end

    // Payload needs no reset: it is only ever observed through the valid bits.
    always_ff @(posedge clk) begin
        if (advance) begin
            gpr_addr_q[0] <= sb.reg_write_addr;
            gpr_rdy_q[0]  <= sb.is_load ? SEL_W'(LOAD_STAGE) : '0;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                gpr_addr_q[s] <= gpr_addr_q[s-1];
                gpr_rdy_q[s]  <= gpr_rdy_q[s-1];
            end
        end
    end

    always_comb begin
        gpr_addr_flat = '0;
        gpr_rdy_flat  = '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            gpr_addr_flat[s*ADDR_W +: ADDR_W] = gpr_addr_q[s];
            gpr_rdy_flat[s*SEL_W +: SEL_W]    = gpr_rdy_q[s];
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        reg_sb_match #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .SEL_W  (SEL_W)
        ) u_match (
            .en        (sb.reg_read_en[p]),
            .addr      (sb.reg_read_addr[p*ADDR_W +: ADDR_W]),
            .ent_valid (gpr_valid_q),
            .ent_addr  (gpr_addr_flat),
            .ent_rdy   (gpr_rdy_flat),
            .fwd_sel   (fwd_sel_flat[p*SEL_W +: SEL_W]),
            .stall     (port_stall[p])
        );
    end

`ifdef REG_SCOREBOARD_CP0_EN
    logic [DEPTH-1:0]  cp_valid_q;
    logic [ADDR_W-1:0] cp_addr_q [DEPTH];
    logic              cp_load;

    assign cp_load = sb.id_valid & sb.cp_write_en & ~id_stall;

    always_ff @(posedge clk) begin
        if (rst || sb.flush) begin
            cp_valid_q <= '0;
        end else if (advance) begin
            cp_valid_q[0] <= cp_load;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                cp_valid_q[s] <= cp_valid_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            cp_addr_q[0] <= sb.cp_write_addr;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                cp_addr_q[s] <= cp_addr_q[s-1];
            end
        end
    end

    // No CP0 forwarding path: mfc0 waits until every matching mtc0 has retired.
    always_comb begin
        cp_stall = 1'b0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            if (cp_valid_q[s] && (cp_addr_q[s] == sb.cp_read_addr)) begin
                cp_stall = sb.cp_read_en;
            end
        end
    end
`else
    logic cp_unused;

    assign cp_stall  = 1'b0;
    assign cp_unused = ^{sb.cp_read_en, sb.cp_read_addr, sb.cp_write_en, sb.cp_write_addr};
`endif

    assign id_stall    = sb.id_valid & ((|port_stall) | cp_stall);
    assign sb.id_stall = id_stall;
    assign sb.fwd_sel  = fwd_sel_flat;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed hazard scenarios followed by
// random traffic, predicted by an age-based in-flight producer list.
module tb_reg_scoreboard;
    localparam int NUM_RD     = 2;
    localparam int DEPTH      = 3;
    localparam int ADDR_W     = 5;
    localparam int LOAD_STAGE = 1;
    localparam int SEL_W      = $clog2(DEPTH + 1);

    typedef struct {
        bit              rst, stall_in, flush, id_valid;
        bit [NUM_RD-1:0] ren;
        int              ra [NUM_RD];
        bit              we;
        int              wa;
        bit              ld;
        bit              cre;
        int              cra;
        bit              cwe;
        int              cwa;
        bit              chk;
    } stim_t;

    typedef struct {
        logic [NUM_RD*SEL_W-1:0] sel;
        logic                    stall;
        bit                      chk;
    } exp_t;

    // One in-flight producer: age = cycles since it left ID, ready = age at
    // which its result can be forwarded.
    typedef struct {
        int addr;
        int age;
        int ready;
        bit cp;
    } prod_t;

    logic  clk;
    logic  rst;
    exp_t  exp_q[$];
    prod_t inflight[$];
    int    total = 0;
    int    bad   = 0;

    reg_scoreboard_if #(.NUM_RD(NUM_RD), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) sb ();

    reg_scoreboard #(
        .NUM_RD     (NUM_RD),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .LOAD_STAGE (LOAD_STAGE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.stall_in = 0; s.flush = 0; s.id_valid = 0;
        s.ren = '0;
        for (int p = 0; p < NUM_RD; p++) s.ra[p] = 0;
        s.we = 0; s.wa = 0; s.ld = 0;
        s.cre = 0; s.cra = 0; s.cwe = 0; s.cwa = 0;
        s.chk = 1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = idle();
        s.rst      = ($urandom_range(0, 99) == 0);
        s.flush    = ($urandom_range(0, 39) == 0);
        s.stall_in = ($urandom_range(0, 6) == 0);
        s.id_valid = ($urandom_range(0, 9) != 0);
        s.ren      = NUM_RD'($urandom);
        for (int p = 0; p < NUM_RD; p++) s.ra[p] = $urandom_range(0, 7);
        s.we  = ($urandom_range(0, 9) < 7);
        s.wa  = $urandom_range(0, 7);
        s.ld  = ($urandom_range(0, 2) == 0);
        s.cre = ($urandom_range(0, 3) == 0);
        s.cra = $urandom_range(11, 13);
        s.cwe = ($urandom_range(0, 3) == 0);
        s.cwa = $urandom_range(11, 13);
        return s;
    endfunction

    function automatic void predict(input stim_t s, output logic [NUM_RD*SEL_W-1:0] sel,
                                    output bit st);
        bit any_st = 0;
        bit cp_st  = 0;
        sel = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            bit found = 0;
            if (s.ren[p] && s.ra[p] != 0) begin
                for (int i = 0; i < inflight.size(); i++) begin
                    if (!found && !inflight[i].cp && inflight[i].addr == s.ra[p]) begin
                        found = 1;
                        if (inflight[i].age >= inflight[i].ready)
                            sel[p*SEL_W +: SEL_W] = SEL_W'(inflight[i].age + 1);
                        else
                            any_st = 1;
                    end
                end
            end
        end
`ifdef REG_SCOREBOARD_CP0_EN
        for (int i = 0; i < inflight.size(); i++)
            if (s.cre && inflight[i].cp && inflight[i].addr == s.cra) cp_st = 1;
`endif
        st = s.id_valid && (any_st || cp_st);
    endfunction

    function automatic void advance_model(input stim_t s, input bit st);
        prod_t n;
        if (s.rst || s.flush) begin
            inflight.delete();
        end else if (!s.stall_in) begin
            for (int i = inflight.size() - 1; i >= 0; i--) begin
                inflight[i].age++;
                if (inflight[i].age >= DEPTH) inflight.delete(i);
            end
            if (s.id_valid && !st) begin
                if (s.we && s.wa != 0) begin
                    n.addr = s.wa; n.age = 0; n.ready = s.ld ? LOAD_STAGE : 0; n.cp = 0;
                    inflight.push_front(n);
                end
`ifdef REG_SCOREBOARD_CP0_EN
                if (s.cwe) begin
                    n.addr = s.cwa; n.age = 0; n.ready = 0; n.cp = 1;
                    inflight.push_front(n);
                end
`endif
            end
        end
    endfunction

    task automatic cyc(input stim_t s, output bit stalled);
        exp_t e;
        logic [NUM_RD*SEL_W-1:0] sel;
        bit st;
        @(negedge clk);
        rst               = s.rst;
        sb.stall_in       = s.stall_in;
        sb.flush          = s.flush;
        sb.id_valid       = s.id_valid;
        sb.reg_read_en    = s.ren;
        for (int p = 0; p < NUM_RD; p++)
            sb.reg_read_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(s.ra[p]);
        sb.reg_write_en   = s.we;
        sb.reg_write_addr = ADDR_W'(s.wa);
        sb.is_load        = s.ld;
        sb.cp_read_en     = s.cre;
        sb.cp_read_addr   = ADDR_W'(s.cra);
        sb.cp_write_en    = s.cwe;
        sb.cp_write_addr  = ADDR_W'(s.cwa);
        predict(s, sel, st);
        e.sel = sel; e.stall = st; e.chk = s.chk;
        exp_q.push_back(e);
        advance_model(s, st);
        stalled = st;
    endtask

    task automatic step(input stim_t s);
        bit dummy;
        cyc(s, dummy);
    endtask

    // Hold the instruction in ID until it is no longer stalled, as the pipeline would.
    task automatic issue(input stim_t s);
        bit stalled = 1;
        int n = 0;
        while (stalled && n < 8) begin
            cyc(s, stalled);
            n++;
        end
        if (stalled) begin
            total++; bad++;
            $display("FAIL issue_bound: still stalled after %0d cycles, required release", n);
        end
    endtask

    // Monitor: outputs are combinational, so one expectation is consumed per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    total++;
                    if (sb.fwd_sel !== e.sel) begin
                        bad++;
                        $display("FAIL fwd_sel t=%0t got=%h exp=%h", $time, sb.fwd_sel, e.sel);
                    end
                    total++;
                    if (sb.id_stall !== e.stall) begin
                        bad++;
                        $display("FAIL id_stall t=%0t got=%b exp=%b", $time, sb.id_stall, e.stall);
                    end
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b0;
        sb.stall_in = 0; sb.flush = 0; sb.id_valid = 0; sb.reg_read_en = '0;
        sb.reg_read_addr = '0; sb.reg_write_en = 0; sb.reg_write_addr = '0; sb.is_load = 0;
        sb.cp_read_en = 0; sb.cp_read_addr = '0; sb.cp_write_en = 0; sb.cp_write_addr = '0;

        // Reset with a write pending: nothing may be tracked.
        s = idle(); s.rst = 1; s.id_valid = 1; s.we = 1; s.wa = 9;
        s.ren = '1; s.ra[0] = 9; s.ra[1] = 9; s.chk = 0;
        step(s);
        s.chk = 1;
        step(s);
        s = idle(); s.id_valid = 1; s.ren = '1; s.ra[0] = 9; s.ra[1] = 9;
        step(s);

        // ALU -> ALU back-to-back, then with one gap.
        s = idle(); s.id_valid = 1; s.we = 1; s.wa = 3; step(s);
        s = idle(); s.id_valid = 1; s.ren = '1; s.ra[0] = 3; s.ra[1] = 1; s.we = 1; s.wa = 4; issue(s);
        s = idle(); s.id_valid = 1; s.we = 1; s.wa = 3; step(s);
        s = idle(); step(s);
        s = idle(); s.id_valid = 1; s.ren = 2'b01; s.ra[0] = 3; issue(s);

        // Load-use on both ports.
        s = idle(); s.id_valid = 1; s.we = 1; s.wa = 5; s.ld = 1; step(s);
        s = idle(); s.id_valid = 1; s.ren = '1; s.ra[0] = 5; s.ra[1] = 5; s.we = 1; s.wa = 6; issue(s);

        // Youngest producer wins.
        s = idle(); s.id_valid = 1; s.we = 1; s.wa = 7; step(s);
        step(s);
        s = idle(); s.id_valid = 1; s.ren = 2'b10; s.ra[1] = 7; issue(s);

        // Freeze during load-use, then flush while frozen.
        s = idle(); s.id_valid = 1; s.we = 1; s.wa = 5; s.ld = 1; step(s);
        s = idle(); s.id_valid = 1; s.ren = 2'b01; s.ra[0] = 5; s.stall_in = 1;
        repeat (3) step(s);
        s.flush = 1; step(s);
        s.flush = 0; s.stall_in = 0; issue(s);

        // Writes to $0 are never tracked.
        s = idle(); s.id_valid = 1; s.we = 1; s.wa = 0; s.ld = 1; step(s);
        s = idle(); s.id_valid = 1; s.ren = '1; s.ra[0] = 0; s.ra[1] = 0; issue(s);

        // mtc0 $12 then mfc0 $12.
        s = idle(); s.id_valid = 1; s.cwe = 1; s.cwa = 12; step(s);
        s = idle(); s.id_valid = 1; s.cre = 1; s.cra = 12; issue(s);

        repeat (800) step(rand_stim());

        #4;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
